// File: rtl/reversible_counter_ctrl_pkg.sv
// Shared types for the reversible counter sequencer: run modes and FSM states.
package reversible_counter_ctrl_pkg;

  localparam int CNT_W = 4;

  // Run modes; the unused encoding 2'b11 behaves as one-shot.
  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_RELOAD   = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/reversible_counter_ctrl_if.sv
// Bundle of experiment controls and counter connections around the sequencer.
interface reversible_counter_ctrl_if #(
  parameter int NPASS_W = 4
) ();
  import reversible_counter_ctrl_pkg::*;

  // experiment controls
  logic               start;
  logic               abort;
  logic               hold;
  logic [1:0]         mode;
  logic               dir_up;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   target;
  logic [NPASS_W-1:0] npass;
  // counter side
  logic [CNT_W-1:0]   q;
  logic               ld_;
  logic               ct_;
  logic               u_;
  logic [CNT_W-1:0]   d;
  // status
  logic               busy;
  logic               done;
  logic [NPASS_W-1:0] passes;

  // Environment: switches, buttons and the counter's Q outputs.
  modport master (
    output start, abort, hold, mode, dir_up, preset, target, npass, q,
    input  ld_, ct_, u_, d, busy, done, passes
  );

  // Sequencer.
  modport slave (
    input  start, abort, hold, mode, dir_up, preset, target, npass, q,
    output ld_, ct_, u_, d, busy, done, passes
  );
endinterface

// File: rtl/reversible_counter_ctrl_pass_counter.sv
// Saturating pass counter with synchronous clear and increment.
module pass_counter
  import reversible_counter_ctrl_pkg::*;
#(
  parameter int NPASS_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [NPASS_W-1:0] count
);

  logic [NPASS_W-1:0] count_q, count_d;

  // Next count: clear wins, increment stops at all-ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + NPASS_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/reversible_counter_ctrl.sv
// Sequencer for one 4-bit up/down loadable counter: loads the preset, enables
// counting until Q reaches the target, then finishes, reloads or reverses.
module reversible_counter_ctrl
  import reversible_counter_ctrl_pkg::*;
#(
  parameter int NPASS_W = 4
) (
  input  logic                     cp,
  input  logic                     cr_,
  reversible_counter_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [NPASS_W-1:0] npass_q, npass_d;
  logic               ld_n_q, ld_n_d;
  logic               u_q, u_d;
  logic [CNT_W-1:0]   d_q, d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               pass_clr, pass_inc;
  logic [NPASS_W-1:0] passes;
  logic               hit;
  logic [NPASS_W:0]   pass_next, pass_limit;
  logic               last_pass;

  pass_counter #(.NPASS_W(NPASS_W)) u_pass_counter (
    .clk   (cp),
    .rst_n (cr_),
    .clr   (pass_clr),
    .inc   (pass_inc),
    .count (passes)
  );

  assign hit        = (bus.q == target_q);
  // One bit wider so the compare is exact even when passes is at all-ones.
  assign pass_next  = {1'b0, passes} + (NPASS_W+1)'(1);
  assign pass_limit = (npass_q == '0) ? (NPASS_W+1)'(1) : {1'b0, npass_q};
  assign last_pass  = (pass_next >= pass_limit);

  // Next-state, working-register and registered-output decode.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    preset_d = preset_q;
    target_d = target_q;
    npass_d  = npass_q;
    pass_clr = 1'b0;
    pass_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d   = bus.mode;
          dir_d    = bus.dir_up;
          preset_d = bus.preset;
          target_d = bus.target;
          npass_d  = bus.npass;
          pass_clr = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = bus.abort ? IDLE : RUN;
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (hit) begin
          pass_inc = 1'b1;
          case (mode_q)
            MODE_RELOAD: state_d = last_pass ? DONE : LOAD;
            MODE_PINGPONG: begin
              if (last_pass) begin
                state_d = DONE;
              end else begin
                preset_d = target_q;
                target_d = preset_q;
                dir_d    = ~dir_q;
              end
            end
            default: state_d = DONE;
          endcase
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    ld_n_d = (state_d != LOAD);
    d_d    = (state_d == LOAD) ? preset_d : d_q;
    u_d    = ((state_d == LOAD) || (state_d == RUN)) ? dir_d : u_q;
    busy_d = (state_d == LOAD) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge cp) begin
    if (!cr_) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      dir_q    <= 1'b0;
      preset_q <= '0;
      target_q <= '0;
      npass_q  <= '0;
      ld_n_q   <= 1'b1;
      u_q      <= 1'b1;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      preset_q <= preset_d;
      target_q <= target_d;
      npass_q  <= npass_d;
      ld_n_q   <= ld_n_d;
      u_q      <= u_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Count enable is decoded combinationally so the counter never steps past
  // the target; abort and reset also freeze Q in their own cycle.
  assign bus.ct_ = ~((state_q == RUN) && cr_ && !bus.abort && !bus.hold && !hit);

  assign bus.ld_    = ld_n_q;
  assign bus.u_     = u_q;
  assign bus.d      = d_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.passes = passes;

endmodule

// File: tb/tb_reversible_counter_ctrl.sv
// Bench for the counter sequencer, driving a behavioural reversible counter.
module tb_reversible_counter_ctrl;

  typedef struct packed {
    logic [3:0] q;
    logic       u;
    logic       ct;
  } obs_t;

  logic cp  = 1'b0;
  logic cr_ = 1'b0;
  logic [3:0] cnt = 4'd0;

  reversible_counter_ctrl_if #(.NPASS_W(4)) bus ();

  reversible_counter_ctrl #(.NPASS_W(4)) dut (
    .cp  (cp),
    .cr_ (cr_),
    .bus (bus)
  );

  always #5 cp = ~cp;

  // Reversible counter: synchronous load, active-low enable, u_=1 counts up.
  always @(posedge cp) begin
    if (bus.ld_ === 1'b0)      cnt <= bus.d;
    else if (bus.ct_ === 1'b0) cnt <= (bus.u_ === 1'b1) ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign bus.q = cnt;

  int   tests = 0;
  int   fails = 0;
  obs_t exp_run[$];
  logic [3:0] exp_done[$];
  obs_t mon_e;
  int   ld_cnt = 0;
  int   last_done_cyc, last_end_cyc;
  int   k_hold_at = 0, k_abort_at = 0, k_rst_at = 0, k_busy_start_at = 0;
  bit   k_start_in_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_obs(input logic [3:0] q, input logic u, input logic ct);
    obs_t o;
    o.q = q; o.u = u; o.ct = ct;
    exp_run.push_back(o);
  endtask

  // One counting leg: every RUN cycle from 'from' to 'to', enable off at 'to'.
  task automatic push_leg(input logic [3:0] from, input logic [3:0] to, input logic up);
    logic [3:0] v;
    v = from;
    for (int i = 0; i < 17; i++) begin
      push_obs(v, up, v == to);
      if (v == to) break;
      v = up ? v + 4'd1 : v - 4'd1;
    end
  endtask

  // Monitor: every RUN cycle (busy, no load) pops one expected observation.
  always @(negedge cp) begin
    if (bus.busy === 1'b1 && bus.ld_ === 1'b1) begin
      if (exp_run.size() == 0) begin
        check("run_unexpected", 32'(exp_run.size()), 32'd1);
      end else begin
        mon_e = exp_run.pop_front();
        check("q",   32'(bus.q),   32'(mon_e.q));
        check("u_",  32'(bus.u_),  32'(mon_e.u));
        check("ct_", 32'(bus.ct_), 32'(mon_e.ct));
      end
    end
    if (bus.ld_ === 1'b0) ld_cnt++;
    if (bus.done === 1'b1) begin
      if (exp_done.size() == 0) check("done_unexpected", 32'(exp_done.size()), 32'd1);
      else check("done_passes", 32'(bus.passes), 32'(exp_done.pop_front()));
    end
  end

  // Starts a run and steps cycle by cycle (cycle 1 = LOAD) until back in IDLE.
  task automatic run_case(input logic [1:0] m, input logic up, input logic [3:0] p,
                          input logic [3:0] t, input logic [3:0] np);
    int cyc;
    ld_cnt = 0;
    last_done_cyc = 0;
    bus.mode = m; bus.dir_up = up; bus.preset = p; bus.target = t; bus.npass = np;
    bus.start = 1'b1;
    @(posedge cp); #1;
    bus.start = 1'b0;
    cyc = 1;
    check("ld_latency", 32'(bus.ld_), 32'd0);
    check("d_preset",   32'(bus.d),   32'(p));
    while (1'b1) begin
      if (bus.done === 1'b1) last_done_cyc = cyc;
      if (cyc > 1 && bus.busy === 1'b0 && bus.done === 1'b0) break;
      if (cyc >= 200) begin
        check("timeout", 32'(cyc), 32'd0);
        break;
      end
      bus.start = (cyc == k_busy_start_at) || (bus.done === 1'b1 && k_start_in_done);
      if (cyc == k_busy_start_at) begin
        bus.preset = 4'd0; bus.target = 4'd0; bus.mode = 2'b01;
      end
      bus.abort = (cyc == k_abort_at);
      bus.hold  = (k_hold_at != 0) && (cyc >= k_hold_at) && (cyc < k_hold_at + 3);
      cr_       = (cyc != k_rst_at);
      @(posedge cp); #1;
      cyc++;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
    last_end_cyc = cyc;
    check("run_drained",  32'(exp_run.size()),  32'd0);
    check("done_drained", 32'(exp_done.size()), 32'd0);
    exp_run.delete();
    exp_done.delete();
    k_hold_at = 0; k_abort_at = 0; k_rst_at = 0; k_busy_start_at = 0; k_start_in_done = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0; bus.mode = 2'b00;
    bus.dir_up = 1'b1; bus.preset = 4'd0; bus.target = 4'd0; bus.npass = 4'd0;
    repeat (2) @(posedge cp);
    #1;
    check("rst_ld_",    32'(bus.ld_),    32'd1);
    check("rst_ct_",    32'(bus.ct_),    32'd1);
    check("rst_u_",     32'(bus.u_),     32'd1);
    check("rst_d",      32'(bus.d),      32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_passes", 32'(bus.passes), 32'd0);
    cr_ = 1'b1;
    @(posedge cp); #1;

    // One-shot up 3->9 (6 steps), start during busy and during DONE ignored.
    push_leg(4'd3, 4'd9, 1'b1);
    exp_done.push_back(4'd1);
    k_busy_start_at = 4;
    k_start_in_done = 1'b1;
    run_case(2'b00, 1'b1, 4'd3, 4'd9, 4'd1);
    check("t1_ld_count", 32'(ld_cnt),        32'd1);
    check("t1_done_cyc", 32'(last_done_cyc), 32'd9);
    check("t1_end_cyc",  32'(last_end_cyc),  32'd10);
    check("t1_q",        32'(bus.q),         32'd9);
    check("t1_passes",   32'(bus.passes),    32'd1);

    // Reload, down through the wrap: 1,0,15,14 three times.
    for (int i = 0; i < 3; i++) push_leg(4'd1, 4'd14, 1'b0);
    exp_done.push_back(4'd3);
    run_case(2'b01, 1'b0, 4'd1, 4'd14, 4'd3);
    check("t2_ld_count", 32'(ld_cnt),     32'd3);
    check("t2_q",        32'(bus.q),      32'd14);
    check("t2_passes",   32'(bus.passes), 32'd3);

    // Ping-pong 2<->5, four legs, single load.
    push_leg(4'd2, 4'd5, 1'b1);
    push_leg(4'd5, 4'd2, 1'b0);
    push_leg(4'd2, 4'd5, 1'b1);
    push_leg(4'd5, 4'd2, 1'b0);
    exp_done.push_back(4'd4);
    run_case(2'b10, 1'b1, 4'd2, 4'd5, 4'd4);
    check("t3_ld_count", 32'(ld_cnt),     32'd1);
    check("t3_q",        32'(bus.q),      32'd2);
    check("t3_passes",   32'(bus.passes), 32'd4);

    // Hold for 3 cycles once q reaches 3, one-shot 0->10.
    for (int v = 0; v < 3; v++) push_obs(4'(v), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push_obs(4'd3, 1'b1, 1'b1);
    for (int v = 3; v < 10; v++) push_obs(4'(v), 1'b1, 1'b0);
    push_obs(4'd10, 1'b1, 1'b1);
    exp_done.push_back(4'd1);
    k_hold_at = 5;
    run_case(2'b00, 1'b1, 4'd0, 4'd10, 4'd1);
    check("t4_q", 32'(bus.q), 32'd10);

    // Abort when q=6 on a 2->12 run: IDLE next cycle, no done, Q frozen.
    for (int v = 2; v < 6; v++) push_obs(4'(v), 1'b1, 1'b0);
    push_obs(4'd6, 1'b1, 1'b1);
    k_abort_at = 6;
    run_case(2'b00, 1'b1, 4'd2, 4'd12, 4'd1);
    check("t5_no_done", 32'(last_done_cyc), 32'd0);
    check("t5_end_cyc", 32'(last_end_cyc),  32'd7);
    check("t5_q",       32'(bus.q),         32'd6);
    check("t5_ct_",     32'(bus.ct_),       32'd1);

    // Reset mid-run on a down count 13->4, asserted when q=10.
    for (int v = 13; v > 10; v--) push_obs(4'(v), 1'b0, 1'b0);
    push_obs(4'd10, 1'b0, 1'b1);
    k_rst_at = 5;
    run_case(2'b00, 1'b0, 4'd13, 4'd4, 4'd1);
    check("t6_ld_",     32'(bus.ld_),    32'd1);
    check("t6_ct_",     32'(bus.ct_),    32'd1);
    check("t6_u_",      32'(bus.u_),     32'd1);
    check("t6_d",       32'(bus.d),      32'd0);
    check("t6_busy",    32'(bus.busy),   32'd0);
    check("t6_done",    32'(bus.done),   32'd0);
    check("t6_passes",  32'(bus.passes), 32'd0);
    check("t6_q",       32'(bus.q),      32'd10);
    check("t6_end_cyc", 32'(last_end_cyc), 32'd6);
    cr_ = 1'b1;

    // preset = target: completes in the first RUN cycle with zero steps.
    push_obs(4'd7, 1'b1, 1'b1);
    exp_done.push_back(4'd1);
    run_case(2'b00, 1'b1, 4'd7, 4'd7, 4'd1);
    check("t7_done_cyc", 32'(last_done_cyc), 32'd3);
    check("t7_q",        32'(bus.q),         32'd7);

    // Reload with npass=0 (one pass), up through the wrap 14->2.
    push_leg(4'd14, 4'd2, 1'b1);
    exp_done.push_back(4'd1);
    run_case(2'b01, 1'b1, 4'd14, 4'd2, 4'd0);
    check("t8_ld_count", 32'(ld_cnt),     32'd1);
    check("t8_passes",   32'(bus.passes), 32'd1);
    check("t8_q",        32'(bus.q),      32'd2);

    // Mode 11 behaves as one-shot even with npass > 1.
    push_leg(4'd8, 4'd6, 1'b0);
    exp_done.push_back(4'd1);
    run_case(2'b11, 1'b0, 4'd8, 4'd6, 4'd5);
    check("t9_ld_count", 32'(ld_cnt),     32'd1);
    check("t9_passes",   32'(bus.passes), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
